shared_unit_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-latency, fully pipelined arithmetic unit (e.g. an i32 or f32 multiplier/adder from the helper library) between up to 16 requesters. It grants at most one operand pair per cycle, drives the shared unit, and tracks requester IDs through a tag pipeline matched to the unit latency. It returns each result, registered, to the requester that issued it. It sits between HIR-generated compute loops and a single instance of an expensive DSP/IP operator.

---
 rtl/shared_unit_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/shared_unit_arbiter.sv | 93 +++++++++
 tb/tb_shared_unit_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_unit_pkg.sv
// rtl/shared_unit_pkg.sv - shared types and constants for the shared arithmetic unit arbiter
// Optional statistics are enabled with SHARED_UNIT_ARBITER_STATS_EN.
package shared_unit_pkg;

  localparam int MAX_REQ     = 16;
  localparam int MAX_LATENCY = 32;
  localparam int MAX_ID_W    = 4;

`ifdef SHARED_UNIT_ARBITER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Tags are sized for the largest legal requester count; narrower builds use the low bits.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - generic round-robin grant with a last-grant pointer
// Grant is combinational and forced low while rst is high.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  logic [ID_W-1:0] last_grant;
  int unsigned     idx_wide;
  logic [ID_W-1:0] idx;

  // Search wraps modulo NUM_REQ so non-power-of-two counts never probe a missing requester.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx_wide    = 0;
    idx         = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx_wide = (32'(last_grant) + 32'(i) + 32'd1) % 32'(NUM_REQ);
        idx      = ID_W'(idx_wide);
        if (!grant_valid && req[idx]) begin
          grant[idx]  = 1'b1;
          grant_id    = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/shared_unit_arbiter.sv
// rtl/shared_unit_arbiter.sv - shares one pipelined arithmetic unit among NUM_REQ requesters
// Define SHARED_UNIT_ARBITER_STATS_EN to add the stat_conflicts counter port.
module shared_unit_arbiter
  import shared_unit_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          op_valid,
  output logic [DATA_WIDTH-1:0]         op_a,
  output logic [DATA_WIDTH-1:0]         op_b,
  input  logic [DATA_WIDTH-1:0]         op_result,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data
`ifdef SHARED_UNIT_ARBITER_STATS_EN
  ,
  output logic [31:0]                   stat_conflicts
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0] grant_id;
  tag_t            tag_q [LATENCY];
  tag_t            tag_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .grant       (req_ready),
    .grant_id    (grant_id),
    .grant_valid (op_valid)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (op_valid) begin
      op_a = req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      op_b = req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Tag pipeline never stalls: the unit is fixed-latency, so depth alone aligns IDs to results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: op_valid, id: MAX_ID_W'(grant_id)};
      for (int s = 1; s < LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tag_last = tag_q[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else if (tag_last.valid) begin
      resp_valid <= NUM_REQ'(1) << tag_last.id;
      resp_data  <= op_result;
    end else begin
      resp_valid <= '0;
    end
  end

`ifdef SHARED_UNIT_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflicts <= '0;
    end else if (($countones(req_valid) > 1) && (stat_conflicts != 32'hFFFF_FFFF)) begin
      stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// tb/tb_shared_unit_arbiter.sv - scoreboard bench for shared_unit_arbiter with a multiply unit model
module tb_shared_unit_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic [NR-1:0]    req_ready;
  logic             op_valid;
  logic [DW-1:0]    op_a, op_b, op_result;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_data;
`ifdef SHARED_UNIT_ARBITER_STATS_EN
  logic [31:0]      stat_conflicts;
`endif

  shared_unit_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .op_valid   (op_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_result  (op_result),
    .resp_valid (resp_valid),
    .resp_data  (resp_data)
`ifdef SHARED_UNIT_ARBITER_STATS_EN
    ,
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Shared multiplier model, deliberately not reset so in-flight results keep emerging.
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= op_valid ? op_a * op_b : '0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign op_result = pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] onehot;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q [$];
  int total = 0;
  int bad = 0;
  logic [DW-1:0] a_val [NR];
  logic [DW-1:0] b_val [NR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_valid", 64'(resp_valid), 64'(e.onehot));
        chk("resp_data", 64'(resp_data), 64'(e.data));
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] exp_g, input bit push);
    int id;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = a_val[i];
      req_b[i*DW +: DW] = b_val[i];
    end
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_g));
    chk("op_valid", 64'(op_valid), 64'(|exp_g));
    if (exp_g != '0) begin
      id = 0;
      for (int i = 0; i < NR; i++) if (exp_g[i]) id = i;
      chk("op_a", 64'(op_a), 64'(a_val[id]));
      chk("op_b", 64'(op_b), 64'(b_val[id]));
      if (push) begin
        e.onehot = exp_g;
        e.data   = a_val[id] * b_val[id];
        e.cyc    = cyc + LAT + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      a_val[i] = '0;
      b_val[i] = '0;
    end
    do_reset();

    // Single requester
    a_val[2] = 32'd3; b_val[2] = 32'd5;
    step(4'b0100, 4'b0100, 1'b1);
    repeat (5) step(4'b0000, 4'b0000, 1'b0);
    drain();

    // Full contention from reset
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a_val[i] = 32'(i + 1);
      b_val[i] = 32'(10 + i);
    end
    for (int r = 0; r < 2; r++) begin
      step(4'b1111, 4'b0001, 1'b1);
      step(4'b1111, 4'b0010, 1'b1);
      step(4'b1111, 4'b0100, 1'b1);
      step(4'b1111, 4'b1000, 1'b1);
    end

    // Pointer wrap after last grant 3
    step(4'b1010, 4'b0010, 1'b1);
    step(4'b1000, 4'b1000, 1'b1);

    // Sustained single requester
    for (int i = 0; i < 10; i++) begin
      a_val[0] = 32'(i); b_val[0] = 32'd2;
      step(4'b0001, 4'b0001, 1'b1);
    end
    repeat (4) step(4'b0000, 4'b0000, 1'b0);
    drain();

    // Reset mid-flight: pointer is 0, so req 1 wins first
    a_val[0] = 32'd7; b_val[0] = 32'd7;
    a_val[1] = 32'd9; b_val[1] = 32'd9;
    step(4'b0011, 4'b0010, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    do_reset();
    repeat (5) step(4'b0000, 4'b0000, 1'b0);
    a_val[0] = 32'd4; b_val[0] = 32'd6;
    step(4'b1111, 4'b0001, 1'b1);
    repeat (4) step(4'b0000, 4'b0000, 1'b0);
    drain();

`ifdef SHARED_UNIT_ARBITER_STATS_EN
    do_reset();
    step(4'b0011, 4'b0001, 1'b1);
    step(4'b0011, 4'b0010, 1'b1);
    step(4'b0011, 4'b0001, 1'b1);
    step(4'b0011, 4'b0010, 1'b1);
    step(4'b0011, 4'b0001, 1'b1);
    repeat (3) step(4'b0001, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    chk("stat_conflicts", 64'(stat_conflicts), 64'd5);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
